// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// State encoding and reset defaults for the PC / fetch unit.
package cpu_pkg;

    localparam int          CPU_INSTR_W  = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetchState_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port plus decode handshake.
// master = fetch unit side, slave = memory / decode side.
interface pc_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = CPU_INSTR_W
);

    logic               imemReq;
    logic [ADDR_W-1:0]  imemAddr;
    logic               imemGnt;
    logic               imemRvalid;
    logic [INSTR_W-1:0] imemRdata;

    logic               instrValid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instrPc;
    logic               instrReady;
    logic               branchMux;
    logic [ADDR_W-1:0]  branchOffset;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemGnt,
        input  imemRvalid,
        input  imemRdata,
        output instrValid,
        output instr,
        output instrPc,
        input  instrReady,
        input  branchMux,
        input  branchOffset
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemGnt,
        output imemRvalid,
        output imemRdata,
        input  instrValid,
        input  instr,
        input  instrPc,
        output instrReady,
        output branchMux,
        output branchOffset
    );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential PC+4 or PC+4 plus word-scaled branch offset.
// Arithmetic wraps modulo 2^ADDR_W.
module pc_next_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] instrPc,
    input  logic              branchMux,
    input  logic [ADDR_W-1:0] branchOffset,
    output logic [ADDR_W-1:0] nextPc
);

    logic [ADDR_W-1:0] seqPc;
    logic [ADDR_W-1:0] brDelta;

    assign seqPc   = instrPc + ADDR_W'(4);
    assign brDelta = branchMux ? (branchOffset << 2) : '0;
    assign nextPc  = seqPc + brDelta;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, single-outstanding instruction fetch and decode handshake.
// Next PC is chosen from branchMux only when decode accepts the held word.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC,
    parameter int              INSTR_W  = CPU_INSTR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt,
    pc_fetch_unit_if.master bus
);

    fetchState_e        state;
    fetchState_e        stateNext;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  nextPc;
    logic [ADDR_W-1:0]  instrPcQ;
    logic [INSTR_W-1:0] instrQ;
    logic               reqOut;
    logic               validOut;
    logic               captureEn;
    logic               acceptEn;

    pc_next_calc #(
        .ADDR_W(ADDR_W)
    ) u_nextCalc (
        .instrPc      (instrPcQ),
        .branchMux    (bus.branchMux),
        .branchOffset (bus.branchOffset),
        .nextPc       (nextPc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        reqOut    = 1'b0;
        validOut  = 1'b0;
        captureEn = 1'b0;
        acceptEn  = 1'b0;
        unique case (1'b1)
            (state == S_FETCH): begin
                reqOut = !halt;
                if (!halt && bus.imemGnt) begin
                    stateNext = S_WAIT;
                end
            end
            (state == S_WAIT): begin
                if (bus.imemRvalid) begin
                    captureEn = 1'b1;
                    stateNext = S_HOLD;
                end
            end
            (state == S_HOLD): begin
                validOut = 1'b1;
                if (bus.instrReady) begin
                    acceptEn  = 1'b1;
                    stateNext = S_FETCH;
                end
            end
            default: begin
                stateNext = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (acceptEn) begin
            pc <= nextPc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrQ   <= '0;
            instrPcQ <= '0;
        end else if (captureEn) begin
            instrQ   <= bus.imemRdata;
            instrPcQ <= pc;
        end
    end

    // State sits in S_FETCH during reset, so the request is masked by rst_n.
    assign bus.imemReq    = reqOut & rst_n;
    assign bus.imemAddr   = {pc[ADDR_W-1:2], 2'b00};
    assign bus.instrValid = validOut;
    assign bus.instr      = instrQ;
    assign bus.instrPc    = instrPcQ;

endmodule
